exec_control_unit: RTL and testbench



---
 rtl/exec_control_unit.sv | 195 +++++++++++++++++++
 tb/tb_exec_control_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_control_unit.sv
// ---------------------------------------------------------------------------
// exec_control_unit
// Execute/control slice of the single-cycle MIPS-subset processor. Decodes
// the instruction word into datapath and PC-control strobes, extends the
// 16-bit immediate, picks the second ALU operand, runs the ALU and keeps the
// status-zero flag used by the bz/bnz status branches.
//
// Ports
//   clk           processor clock (st_z loads on the falling edge)
//   reset         asynchronous, active-high; clears st_z
//   instruction   current 32-bit instruction word
//   data_a        rs value, always ALU input 1
//   data_b        rt value, ALU input 2 when alu_src=0
//   reg_write .. mem_to_reg      datapath control strobes
//   is_jump .. need_st_z         PC-control strobes
//   alu_op        ALU operation (ADD,SUB,AND,OR,XOR,SLT,SLL,SRL)
//   pc_select     00 sequential/branch, 01 addr26 jump, 10 register jump
//   ext_imm16     sign- or zero-extended immediate
//   alu_out       ALU result
//   alu_zero      alu_out == 0
//   st_z          registered status-zero flag
// ---------------------------------------------------------------------------
module exec_control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [31:0] data_a,
  input  logic [31:0] data_b,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        write_reg31,
  output logic        link,
  output logic        alu_src,
  output logic        ext_op,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        is_jump,
  output logic        zero_branch,
  output logic        need_zero,
  output logic        status_branch,
  output logic        need_st_z,
  output logic [2:0]  alu_op,
  output logic [1:0]  pc_select,
  output logic [31:0] ext_imm16,
  output logic [31:0] alu_out,
  output logic        alu_zero,
  output logic        st_z
);

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } aluOp_t;

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [4:0]  w_shamt;
  logic [15:0] w_imm16;
  logic [31:0] w_aluIn2;
  logic [31:0] w_aluResult;
  logic        r_stZ;

  assign w_opcode = instruction[31:26];
  assign w_funct  = instruction[5:0];
  assign w_shamt  = instruction[10:6];
  assign w_imm16  = instruction[15:0];

  // Decoder. Anything not recognised keeps the defaults, which means no
  // register or memory write and sequential PC.
  always_comb begin
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    write_reg31   = 1'b0;
    link          = 1'b0;
    alu_src       = 1'b0;
    ext_op        = 1'b1;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    is_jump       = 1'b0;
    zero_branch   = 1'b0;
    need_zero     = 1'b0;
    status_branch = 1'b0;
    need_st_z     = 1'b0;
    alu_op        = ALU_ADD;
    pc_select     = 2'b00;

    case (w_opcode)
      6'h00: begin
        case (w_funct)
          6'h20, 6'h21: begin reg_write = 1'b1; alu_op = ALU_ADD; end
          6'h22, 6'h23: begin reg_write = 1'b1; alu_op = ALU_SUB; end
          6'h24:        begin reg_write = 1'b1; alu_op = ALU_AND; end
          6'h25:        begin reg_write = 1'b1; alu_op = ALU_OR;  end
          6'h26:        begin reg_write = 1'b1; alu_op = ALU_XOR; end
          6'h2A:        begin reg_write = 1'b1; alu_op = ALU_SLT; end
          6'h00:        begin reg_write = 1'b1; alu_op = ALU_SLL; end
          6'h02:        begin reg_write = 1'b1; alu_op = ALU_SRL; end
          6'h08: begin
            is_jump   = 1'b1;
            pc_select = 2'b10;
          end
          default: ;
        endcase
      end
      6'h08, 6'h09: begin
        reg_write = 1'b1; reg_dst = 1'b1; alu_src = 1'b1;
        alu_op    = ALU_ADD;
      end
      6'h0A: begin
        reg_write = 1'b1; reg_dst = 1'b1; alu_src = 1'b1;
        alu_op    = ALU_SLT;
      end
      6'h0C: begin
        reg_write = 1'b1; reg_dst = 1'b1; alu_src = 1'b1;
        ext_op    = 1'b0; alu_op = ALU_AND;
      end
      6'h0D: begin
        reg_write = 1'b1; reg_dst = 1'b1; alu_src = 1'b1;
        ext_op    = 1'b0; alu_op = ALU_OR;
      end
      6'h0E: begin
        reg_write = 1'b1; reg_dst = 1'b1; alu_src = 1'b1;
        ext_op    = 1'b0; alu_op = ALU_XOR;
      end
      6'h23: begin
        reg_write  = 1'b1; reg_dst = 1'b1; alu_src = 1'b1;
        mem_to_reg = 1'b1;
      end
      6'h2B: begin
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      6'h04: begin
        alu_op = ALU_SUB; zero_branch = 1'b1; need_zero = 1'b1;
      end
      6'h05: begin
        alu_op = ALU_SUB; zero_branch = 1'b1;
      end
      6'h06: begin
        status_branch = 1'b1; need_st_z = 1'b1;
      end
      6'h07: begin
        status_branch = 1'b1;
      end
      6'h02: begin
        is_jump = 1'b1; pc_select = 2'b01;
      end
      // jal leaves reg_write low: the r31 write is qualified outside this
      // block by branch_taken.
      6'h03: begin
        is_jump = 1'b1; pc_select = 2'b01;
        link    = 1'b1; write_reg31 = 1'b1;
      end
      default: ;
    endcase
  end

  assign ext_imm16 = ext_op ? {{16{w_imm16[15]}}, w_imm16} : {16'h0000, w_imm16};
  assign w_aluIn2  = alu_src ? ext_imm16 : data_b;

  // ALU. Shifts act on operand 2 by the shamt field, as MIPS sll/srl do.
  always_comb begin
    w_aluResult = 32'h0;
    case (alu_op)
      ALU_ADD: w_aluResult = data_a + w_aluIn2;
      ALU_SUB: w_aluResult = data_a - w_aluIn2;
      ALU_AND: w_aluResult = data_a & w_aluIn2;
      ALU_OR:  w_aluResult = data_a | w_aluIn2;
      ALU_XOR: w_aluResult = data_a ^ w_aluIn2;
      ALU_SLT: w_aluResult = {31'h0, ($signed(data_a) < $signed(w_aluIn2))};
      ALU_SLL: w_aluResult = w_aluIn2 << w_shamt;
      ALU_SRL: w_aluResult = w_aluIn2 >> w_shamt;
      default: w_aluResult = 32'h0;
    endcase
  end

  assign alu_out  = w_aluResult;
  assign alu_zero = (w_aluResult == 32'h0);

  // Status flag loads on the falling edge so the fetch unit can sample a
  // settled value on the next rising edge.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) r_stZ <= 1'b0;
    else       r_stZ <= (w_aluResult == 32'h0);
  end

  assign st_z = r_stZ;

endmodule

// File: tb/tb_exec_control_unit.sv
// ---------------------------------------------------------------------------
// tb_exec_control_unit
// Self-checking bench for exec_control_unit: directed vectors followed by
// randomized instructions, compared against a mnemonic-level reference model.
// ---------------------------------------------------------------------------
module tb_exec_control_unit;

  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic        reg_write, reg_dst, write_reg31, link, alu_src, ext_op;
  logic        mem_write, mem_to_reg, is_jump, zero_branch, need_zero;
  logic        status_branch, need_st_z;
  logic [2:0]  alu_op;
  logic [1:0]  pc_select;
  logic [31:0] ext_imm16;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        st_z;

  int checkCount = 0;
  int failCount  = 0;

  exec_control_unit dut (
    .clk(clk), .reset(reset), .instruction(instruction),
    .data_a(data_a), .data_b(data_b),
    .reg_write(reg_write), .reg_dst(reg_dst), .write_reg31(write_reg31),
    .link(link), .alu_src(alu_src), .ext_op(ext_op),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .is_jump(is_jump),
    .zero_branch(zero_branch), .need_zero(need_zero),
    .status_branch(status_branch), .need_st_z(need_st_z),
    .alu_op(alu_op), .pc_select(pc_select), .ext_imm16(ext_imm16),
    .alu_out(alu_out), .alu_zero(alu_zero), .st_z(st_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation and count it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Reference model: instruction -> mnemonic -> behaviour.
  function automatic string mnem(input logic [31:0] ins);
    case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h20: return "add";  6'h21: return "addu";
        6'h22: return "sub";  6'h23: return "subu";
        6'h24: return "and";  6'h25: return "or";
        6'h26: return "xor";  6'h2A: return "slt";
        6'h00: return "sll";  6'h02: return "srl";
        6'h08: return "jr";
        default: return "rnone";
      endcase
      6'h08: return "addi";  6'h09: return "addiu";
      6'h0A: return "slti";  6'h0C: return "andi";
      6'h0D: return "ori";   6'h0E: return "xori";
      6'h23: return "lw";    6'h2B: return "sw";
      6'h04: return "beq";   6'h05: return "bne";
      6'h06: return "bz";    6'h07: return "bnz";
      6'h02: return "j";     6'h03: return "jal";
      default: return "undef";
    endcase
  endfunction

  function automatic string aluFn(input string m);
    if (m == "sub" || m == "subu" || m == "beq" || m == "bne") return "sub";
    if (m == "and" || m == "andi") return "and";
    if (m == "or"  || m == "ori")  return "or";
    if (m == "xor" || m == "xori") return "xor";
    if (m == "slt" || m == "slti") return "slt";
    if (m == "sll") return "sll";
    if (m == "srl") return "srl";
    return "add";
  endfunction

  function automatic logic [2:0] aluCode(input string f);
    if (f == "sub") return 3'd1;
    if (f == "and") return 3'd2;
    if (f == "or")  return 3'd3;
    if (f == "xor") return 3'd4;
    if (f == "slt") return 3'd5;
    if (f == "sll") return 3'd6;
    if (f == "srl") return 3'd7;
    return 3'd0;
  endfunction

  function automatic logic zeroExt(input string m);
    return (m == "andi" || m == "ori" || m == "xori");
  endfunction

  function automatic logic usesImm(input string m);
    return (m == "addi" || m == "addiu" || m == "slti" || zeroExt(m) ||
            m == "lw" || m == "sw");
  endfunction

  // Control vector in the order {reg_write, reg_dst, write_reg31, link,
  // alu_src, ext_op, mem_write, mem_to_reg, is_jump, zero_branch, need_zero,
  // status_branch, need_st_z, alu_op, pc_select}.
  function automatic logic [17:0] expCtrl(input string m);
    logic rArith, iArith;
    logic [1:0] pcSel;
    rArith = (m == "add" || m == "addu" || m == "sub" || m == "subu" ||
              m == "and" || m == "or" || m == "xor" || m == "slt" ||
              m == "sll" || m == "srl");
    iArith = usesImm(m) && m != "lw" && m != "sw";
    pcSel  = (m == "j" || m == "jal") ? 2'b01 : (m == "jr") ? 2'b10 : 2'b00;
    return {rArith || iArith || m == "lw", iArith || m == "lw",
            m == "jal", m == "jal", usesImm(m), !zeroExt(m),
            m == "sw", m == "lw", m == "j" || m == "jal" || m == "jr",
            m == "beq" || m == "bne", m == "beq",
            m == "bz" || m == "bnz", m == "bz",
            aluCode(aluFn(m)), pcSel};
  endfunction

  function automatic logic [31:0] expExt(input logic [31:0] ins);
    int signed sv;
    if (zeroExt(mnem(ins))) return {16'h0, ins[15:0]};
    sv = int'($signed(ins[15:0]));
    return sv;
  endfunction

  function automatic logic [31:0] expAlu(input logic [31:0] ins,
                                         input logic [31:0] a, input logic [31:0] b);
    string f;
    logic [31:0] op2;
    int unsigned sh;
    f   = aluFn(mnem(ins));
    op2 = usesImm(mnem(ins)) ? expExt(ins) : b;
    sh  = ins[10:6];
    if (f == "sub") return a - op2;
    if (f == "and") return a & op2;
    if (f == "or")  return a | op2;
    if (f == "xor") return a ^ op2;
    if (f == "slt") return (int'(a) < int'(op2)) ? 32'd1 : 32'd0;
    if (f == "sll") return op2 << sh;
    if (f == "srl") return op2 >> sh;
    return a + op2;
  endfunction

  function automatic logic [31:0] rType(input logic [5:0] funct, input logic [4:0] shamt);
    return {6'h00, 5'd1, 5'd2, 5'd3, shamt, funct};
  endfunction

  function automatic logic [31:0] iType(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd1, 5'd2, imm};
  endfunction

  // Drive one instruction after a rising edge, check the combinational
  // outputs, then check the flag captured at the following falling edge.
  task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] a,
                               input logic [31:0] b);
    logic [31:0] expRes;
    @(posedge clk);
    #1;
    instruction = ins;
    data_a      = a;
    data_b      = b;
    expRes      = expAlu(ins, a, b);
    #1;
    checkOutput({"ctrl_", mnem(ins)},
                {14'h0, reg_write, reg_dst, write_reg31, link, alu_src, ext_op,
                 mem_write, mem_to_reg, is_jump, zero_branch, need_zero,
                 status_branch, need_st_z, alu_op, pc_select},
                {14'h0, expCtrl(mnem(ins))});
    checkOutput({"ext_", mnem(ins)}, ext_imm16, expExt(ins));
    checkOutput({"alu_", mnem(ins)}, alu_out, expRes);
    checkOutput({"zero_", mnem(ins)}, {31'h0, alu_zero}, {31'h0, expRes == 32'h0});
    @(negedge clk);
    #1;
    checkOutput({"stz_", mnem(ins)}, {31'h0, st_z}, {31'h0, expRes == 32'h0});
  endtask

  logic [5:0] opList [16] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D,
                              6'h0E, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h06, 6'h02, 6'h03};
  logic [5:0] fnList [11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                              6'h2A, 6'h00, 6'h02, 6'h08};

  initial begin
    logic [31:0] ins, a, b;
    reset       = 1'b1;
    instruction = 32'h0;
    data_a      = 32'h0;
    data_b      = 32'h0;
    #1;
    checkOutput("reset_stz", {31'h0, st_z}, 32'h0);
    // Instruction 0 is sll by 0 of 0, so the ALU reads zero; the flag must
    // still stay clear while reset is held.
    @(negedge clk);
    #1;
    checkOutput("reset_hold_stz", {31'h0, st_z}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed vectors.
    applyStimulus(rType(6'h20, 5'd0), 32'd5, 32'hFFFF_FFFF);
    checkOutput("add_wrap", alu_out, 32'd4);
    applyStimulus(rType(6'h22, 5'd0), 32'd3, 32'd3);
    checkOutput("sub_zero_stz", {31'h0, st_z}, 32'd1);
    applyStimulus(iType(6'h08, 16'h0007), 32'd0, 32'h0);
    checkOutput("addi_seven_stz", {31'h0, st_z}, 32'd0);
    applyStimulus(iType(6'h08, 16'h8000), 32'd0, 32'h1234);
    checkOutput("addi_sext", alu_out, 32'hFFFF_8000);
    applyStimulus(iType(6'h0D, 16'h8000), 32'd1, 32'h0);
    checkOutput("ori_zext", alu_out, 32'h0000_8001);
    applyStimulus(rType(6'h00, 5'd4), 32'h0, 32'h0F);
    checkOutput("sll4", alu_out, 32'hF0);
    applyStimulus(rType(6'h02, 5'd31), 32'h0, 32'h8000_0000);
    checkOutput("srl31", alu_out, 32'd1);
    applyStimulus(rType(6'h2A, 5'd0), 32'hFFFF_FFFF, 32'd1);
    checkOutput("slt_signed", alu_out, 32'd1);
    applyStimulus(iType(6'h23, 16'h0010), 32'h100, 32'h0);
    applyStimulus(iType(6'h2B, 16'hFFFC), 32'h100, 32'h0);
    applyStimulus(iType(6'h04, 16'h0004), 32'd9, 32'd9);
    applyStimulus(iType(6'h05, 16'h0004), 32'd9, 32'd8);
    applyStimulus(iType(6'h06, 16'h0004), 32'd0, 32'd0);
    applyStimulus(iType(6'h07, 16'h0004), 32'd1, 32'd0);
    applyStimulus({6'h02, 26'h123_4567}, 32'd2, 32'd3);
    applyStimulus({6'h03, 26'h012_3456}, 32'd2, 32'd3);
    applyStimulus(rType(6'h08, 5'd0), 32'h400, 32'd3);
    applyStimulus({6'h3F, 26'h3FF_FFFF}, 32'd1, 32'd2);
    applyStimulus(rType(6'h3F, 5'd0), 32'd1, 32'd2);

    // Flag set, then reset asserted mid-cycle must clear it asynchronously.
    applyStimulus(rType(6'h22, 5'd0), 32'd77, 32'd77);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midcycle_reset_stz", {31'h0, st_z}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("post_reset_load_stz", {31'h0, st_z}, 32'd1);

    // Randomized instructions; a quarter of the time rt equals rs so that
    // zero results and branch-equal cases show up.
    for (int i = 0; i < 300; i++) begin
      ins = $urandom;
      if ($urandom_range(0, 9) != 0) ins[31:26] = opList[$urandom_range(0, 15)];
      if (ins[31:26] == 6'h00 && $urandom_range(0, 7) != 0)
        ins[5:0] = fnList[$urandom_range(0, 10)];
      a = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      applyStimulus(ins, a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
